aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_key_expander_if.sv | 45 ++++
 rtl/aes_key_expander.sv | 260 ++++++++++++++++++++++++++
 tb/tb_aes_key_expander.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// AES key expander request/read bundle.
// Optional rk_rev port under AES_KEYEXP_REVERSE_EN.
interface aes_key_expander_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         err;
  logic         key_valid;
  logic [3:0]   nr;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef AES_KEYEXP_REVERSE_EN
  logic         rk_rev;

  modport master (
    output start, key_len, key_in,
    output rk_idx, rk_rev,
    input  busy, done, err,
    input  key_valid, nr, rk_out
  );

  modport slave (
    input  start, key_len, key_in,
    input  rk_idx, rk_rev,
    output busy, done, err,
    output key_valid, nr, rk_out
  );
`else
  modport master (
    output start, key_len, key_in,
    output rk_idx,
    input  busy, done, err,
    input  key_valid, nr, rk_out
  );

  modport slave (
    input  start, key_len, key_in,
    input  rk_idx,
    output busy, done, err,
    output key_valid, nr, rk_out
  );
`endif
endinterface

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule, one word per cycle.
// Macro AES_KEYEXP_REVERSE_EN adds reverse-order reads.
module aes_key_expander #(
  parameter int MAX_NK = 8
) (
  input logic clk,
  input logic rst,
  aes_key_expander_if.slave bus
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAXNK = 4'(MAX_NK);

  typedef enum logic [0:0] {
    IDLE,
    EXPAND
  } state_t;

  state_t state_q, state_d;

  logic [3:0]   nk_q;
  logic [3:0]   nr_q;
  logic [5:0]   i_q;
  logic [5:0]   last_q;
  logic [2:0]   cnt_q;
  logic [7:0]   rc_q;
  logic         key_valid_q;
  logic         done_q;
  logic         err_q;
  logic [127:0] rk_q;
  logic [31:0]  win_q [8];
  logic [31:0]  mem_q [DEPTH];

  logic [31:0]  kw [8];
  logic [3:0]   req_nk;
  logic         req_ok;
  logic         accept;
  logic         reject;
  logic         expand;
  logic         last_w;
  logic [3:0]   oidx;
  logic [31:0]  prev_w;
  logic [31:0]  old_w;
  logic [31:0]  sub_in;
  logic [31:0]  sub_w;
  logic [31:0]  temp_w;
  logic [31:0]  new_w;
  logic [3:0]   eff_idx;
  logic [5:0]   base;
  logic         rd_ok;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse (0 maps to 0)
  function automatic logic [7:0] ginv(
    input logic [7:0] a
  );
    logic [7:0] x2, x3, x6, x12, x15;
    logic [7:0] x30, x60, x120, x240, x252;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] b;
    b = ginv(a);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  // split the left-aligned key into words
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      kw[k] = bus.key_in[255 - 32*k -: 32];
    end
  end

  // key length decode and start qualification
  always_comb begin
    req_nk = 4'd0;
    unique case (1'b1)
      (bus.key_len == 2'b00): req_nk = 4'd4;
      (bus.key_len == 2'b01): req_nk = 4'd6;
      (bus.key_len == 2'b10): req_nk = 4'd8;
      default:                req_nk = 4'd0;
    endcase
    req_ok = (req_nk != 4'd0) && (req_nk <= MAXNK);
  end

  assign accept = !rst && (state_q == IDLE)
                  && bus.start && req_ok;
  assign reject = (state_q == IDLE)
                  && bus.start && !req_ok;
  assign expand = (state_q == EXPAND);
  assign last_w = (i_q == last_q);

  // next schedule word from the sliding window
  always_comb begin
    oidx   = 4'd8 - nk_q;
    prev_w = win_q[7];
    old_w  = win_q[oidx[2:0]];
    sub_in = (cnt_q == 3'd0)
             ? {prev_w[23:0], prev_w[31:24]}
             : prev_w;
    sub_w  = subword(sub_in);
    temp_w = prev_w;
    if (cnt_q == 3'd0) begin
      temp_w = sub_w ^ {rc_q, 24'h0};
    end else if ((nk_q == 4'd8) && (cnt_q == 3'd4)) begin
      temp_w = sub_w;
    end
    new_w = old_w ^ temp_w;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = EXPAND;
      EXPAND: if (last_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // schedule control, counters and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      nk_q        <= 4'd4;
      nr_q        <= 4'd0;
      i_q         <= 6'd0;
      last_q      <= 6'd0;
      cnt_q       <= 3'd0;
      rc_q        <= 8'h00;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        nk_q        <= req_nk;
        nr_q        <= req_nk + 4'd6;
        i_q         <= {2'b00, req_nk};
        last_q      <= {req_nk, 2'b00} + 6'd27;
        cnt_q       <= 3'd0;
        rc_q        <= 8'h01;
        key_valid_q <= 1'b0;
      end else if (expand) begin
        i_q <= i_q + 6'd1;
        if (cnt_q == 3'(nk_q - 4'd1)) cnt_q <= 3'd0;
        else                          cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd0) rc_q <= xtime(rc_q);
        if (last_w) begin
          done_q      <= 1'b1;
          key_valid_q <= 1'b1;
        end
      end else if (reject) begin
        err_q <= 1'b1;
      end
    end
  end

  // key storage and sliding window, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= kw[k];
        win_q[k] <= kw[3'(k) + req_nk[2:0]];
      end
    end else if (expand) begin
      mem_q[i_q] <= new_w;
      for (int k = 0; k < 7; k++) begin
        win_q[k] <= win_q[k+1];
      end
      win_q[7] <= new_w;
    end
  end

  // read index and range check
  always_comb begin
`ifdef AES_KEYEXP_REVERSE_EN
    eff_idx = bus.rk_rev ? (nr_q - bus.rk_idx)
                         : bus.rk_idx;
`else
    eff_idx = bus.rk_idx;
`endif
    base  = {eff_idx, 2'b00};
    rd_ok = key_valid_q && (state_q == IDLE)
            && (bus.rk_idx <= nr_q);
  end

  // registered round-key read port
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q <= '0;
    end else if (rd_ok) begin
      rk_q <= {mem_q[base],
               mem_q[base + 6'd1],
               mem_q[base + 6'd2],
               mem_q[base + 6'd3]};
    end else begin
      rk_q <= '0;
    end
  end

  assign bus.busy      = expand;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.key_valid = key_valid_q;
  assign bus.nr        = nr_q;
  assign bus.rk_out    = rk_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander (FIPS-197 vectors).
// A second instance with MAX_NK=4 covers length rejection.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
     64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R128_0  =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  =
    128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 =
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 =
    128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 =
    128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_expander_if bus ();
  aes_key_expander_if bus4 ();

  aes_key_expander #(.MAX_NK(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  aes_key_expander #(.MAX_NK(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  task automatic run_key(
    input  logic [1:0]   kl,
    input  logic [255:0] key,
    output int           cycles
  );
    bus.key_len = kl;
    bus.key_in  = key;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 0;
    while (!bus.done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic rd(
    input  logic [3:0]   idx,
    output logic [127:0] v
  );
    bus.rk_idx = idx;
    @(negedge clk);
    v = bus.rk_out;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    total++;
    if (bus.key_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_kv got %b want 0", bus.key_valid);
    end
    total++;
    if ({bus.done, bus.err} !== 2'b00) begin
      bad++;
      $display("FAIL reset_done_err got %b want 00",
               {bus.done, bus.err});
    end
    total++;
    if (bus.nr !== 4'd0) begin
      bad++;
      $display("FAIL reset_nr got %0d want 0", bus.nr);
    end
    total++;
    if (bus.rk_out !== 128'h0) begin
      bad++;
      $display("FAIL reset_rk got %h want 0", bus.rk_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aes128;
    int cyc;
    logic [127:0] v;
    bus.key_len = 2'b00;
    bus.key_in  = K128;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL a128_busy got %b want 1", bus.busy);
    end
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 40) begin
      bad++;
      $display("FAIL a128_cycles got %0d want 40", cyc);
    end
    total++;
    if (bus.nr !== 4'd10) begin
      bad++;
      $display("FAIL a128_nr got %0d want 10", bus.nr);
    end
    rd(4'd0, v);
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL a128_done_pulse got %b want 0", bus.done);
    end
    total++;
    if (v !== R128_0) begin
      bad++;
      $display("FAIL a128_rk0 got %h want %h", v, R128_0);
    end
    rd(4'd1, v);
    total++;
    if (v !== R128_1) begin
      bad++;
      $display("FAIL a128_rk1 got %h want %h", v, R128_1);
    end
    rd(4'd10, v);
    total++;
    if (v !== R128_10) begin
      bad++;
      $display("FAIL a128_rk10 got %h want %h", v, R128_10);
    end
    rd(4'd11, v);
    total++;
    if (v !== 128'h0) begin
      bad++;
      $display("FAIL a128_rk11 got %h want 0", v);
    end
  endtask

  task automatic test_reserved;
    logic [127:0] v;
    bus.key_len = 2'b11;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if ({bus.err, bus.busy} !== 2'b10) begin
      bad++;
      $display("FAIL rsv_err_busy got %b want 10",
               {bus.err, bus.busy});
    end
    @(negedge clk);
    total++;
    if ({bus.err, bus.busy, bus.key_valid} !== 3'b001) begin
      bad++;
      $display("FAIL rsv_after got %b want 001",
               {bus.err, bus.busy, bus.key_valid});
    end
    rd(4'd10, v);
    total++;
    if (v !== R128_10) begin
      bad++;
      $display("FAIL rsv_rk10 got %h want %h", v, R128_10);
    end
  endtask

`ifdef AES_KEYEXP_REVERSE_EN
  task automatic test_reverse;
    logic [127:0] v;
    bus.rk_rev = 1'b1;
    rd(4'd0, v);
    total++;
    if (v !== R128_10) begin
      bad++;
      $display("FAIL rev_idx0 got %h want %h", v, R128_10);
    end
    rd(4'd10, v);
    total++;
    if (v !== R128_0) begin
      bad++;
      $display("FAIL rev_idx10 got %h want %h", v, R128_0);
    end
    rd(4'd11, v);
    total++;
    if (v !== 128'h0) begin
      bad++;
      $display("FAIL rev_idx11 got %h want 0", v);
    end
    bus.rk_rev = 1'b0;
  endtask
`endif

  task automatic test_aes192;
    int cyc;
    logic [127:0] v;
    run_key(2'b01, K192, cyc);
    total++;
    if (cyc !== 46) begin
      bad++;
      $display("FAIL a192_cycles got %0d want 46", cyc);
    end
    total++;
    if (bus.nr !== 4'd12) begin
      bad++;
      $display("FAIL a192_nr got %0d want 12", bus.nr);
    end
    rd(4'd12, v);
    total++;
    if (v !== R192_12) begin
      bad++;
      $display("FAIL a192_rk12 got %h want %h", v, R192_12);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit err_seen;
    logic [127:0] v;
    bus.key_len = 2'b10;
    bus.key_in  = K256;
    bus.rk_idx  = 4'd0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.rk_out !== R192_12 && bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy got %b want 1", bus.busy);
    end
    cyc = 0;
    err_seen = 1'b0;
    while (!bus.done && cyc < 100) begin
      bus.start = (cyc == 5) || (cyc == 7);
      bus.key_len = (cyc == 7) ? 2'b11 : 2'b00;
      @(negedge clk);
      cyc++;
      if (bus.err) err_seen = 1'b1;
      if (cyc == 10) begin
        total++;
        if (bus.rk_out !== 128'h0) begin
          bad++;
          $display("FAIL b2b_busy_read got %h want 0",
                   bus.rk_out);
        end
      end
    end
    bus.start = 1'b0;
    total++;
    if (cyc !== 52) begin
      bad++;
      $display("FAIL a256_cycles got %0d want 52", cyc);
    end
    total++;
    if (err_seen !== 1'b0) begin
      bad++;
      $display("FAIL b2b_err got %b want 0", err_seen);
    end
    total++;
    if (bus.nr !== 4'd14) begin
      bad++;
      $display("FAIL a256_nr got %0d want 14", bus.nr);
    end
    rd(4'd14, v);
    total++;
    if (v !== R256_14) begin
      bad++;
      $display("FAIL a256_rk14 got %h want %h", v, R256_14);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [127:0] v;
    bus.key_len = 2'b00;
    bus.key_in  = K128;
    bus.rk_idx  = 4'd1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus.busy, bus.key_valid, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst_flags got %b want 000",
               {bus.busy, bus.key_valid, bus.done});
    end
    total++;
    if (bus.rk_out !== 128'h0) begin
      bad++;
      $display("FAIL mid_rst_rk got %h want 0", bus.rk_out);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_idle got %b want 0", bus.busy);
    end
    run_key(2'b00, K128, cyc);
    total++;
    if (cyc !== 40) begin
      bad++;
      $display("FAIL mid_rerun_cycles got %0d want 40", cyc);
    end
    rd(4'd1, v);
    total++;
    if (v !== R128_1) begin
      bad++;
      $display("FAIL mid_rerun_rk1 got %h want %h", v, R128_1);
    end
    rd(4'd10, v);
    total++;
    if (v !== R128_10) begin
      bad++;
      $display("FAIL mid_rerun_rk10 got %h want %h",
               v, R128_10);
    end
  endtask

  task automatic test_nk_limit;
    int cyc;
    bus4.key_len = 2'b00;
    bus4.key_in  = K128;
    bus4.rk_idx  = 4'd1;
    bus4.start   = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    cyc = 0;
    while (!bus4.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 40) begin
      bad++;
      $display("FAIL nk4_cycles got %0d want 40", cyc);
    end
    bus4.key_len = 2'b10;
    bus4.key_in  = K256;
    bus4.start   = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    total++;
    if ({bus4.err, bus4.busy} !== 2'b10) begin
      bad++;
      $display("FAIL nk4_err_busy got %b want 10",
               {bus4.err, bus4.busy});
    end
    @(negedge clk);
    total++;
    if ({bus4.err, bus4.busy, bus4.key_valid} !== 3'b001) begin
      bad++;
      $display("FAIL nk4_after got %b want 001",
               {bus4.err, bus4.busy, bus4.key_valid});
    end
    total++;
    if (bus4.rk_out !== R128_1) begin
      bad++;
      $display("FAIL nk4_rk1 got %h want %h",
               bus4.rk_out, R128_1);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_len  = 2'b00;
    bus.key_in   = '0;
    bus.rk_idx   = 4'd0;
    bus4.start   = 1'b0;
    bus4.key_len = 2'b00;
    bus4.key_in  = '0;
    bus4.rk_idx  = 4'd0;
`ifdef AES_KEYEXP_REVERSE_EN
    bus.rk_rev   = 1'b0;
    bus4.rk_rev  = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_aes128();
    test_reserved();
`ifdef AES_KEYEXP_REVERSE_EN
    test_reverse();
`endif
    test_aes192();
    test_back_to_back();
    test_reset_mid();
    test_nk_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
